// File: rtl/trap_unit_pkg.sv
// trap_unit_pkg: shared CSR addresses, cause codes, mip bit positions and FSM encoding for trap_unit.
package trap_unit_pkg;
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MIRQMODE = 12'h7C0;

    localparam int MSTATUS_MIE   = 3;
    localparam int MSTATUS_MPIE  = 7;
    localparam int MIP_MSI       = 3;
    localparam int MIP_MTI       = 7;
    localparam int MIP_MEI       = 11;
    localparam int MIP_USER_BASE = 16;

    localparam logic [4:0] CAUSE_MSI = 5'd3;
    localparam logic [4:0] CAUSE_MTI = 5'd7;
    localparam logic [4:0] CAUSE_MEI = 5'd11;

    typedef enum logic {RUN, ENTRY} trapState_e;

    function automatic logic isOwned(input logic [11:0] addr);
        return addr inside {CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
                            CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MIRQMODE};
    endfunction
endpackage

// File: rtl/trap_irq_priority.sv
// trap_irq_priority: picks the winning interrupt from the enabled-pending vector (MEI > MSI > MTI > user, low index first).
module trap_irq_priority
    import trap_unit_pkg::*;
#(
    parameter int USER_IRQ_COUNT = 16
) (
    input  logic [31:0] pending,
    output logic        valid,
    output logic [4:0]  code
);
    always_comb begin
        valid = |pending;
        code  = '0;
        // Scan users high to low so the lowest index is assigned last and wins.
        for (int i = USER_IRQ_COUNT - 1; i >= 0; i--)
            if (pending[MIP_USER_BASE + i]) code = 5'(MIP_USER_BASE + i);
        if (pending[MIP_MTI]) code = CAUSE_MTI;
        if (pending[MIP_MSI]) code = CAUSE_MSI;
        if (pending[MIP_MEI]) code = CAUSE_MEI;
    end
endmodule

// File: rtl/trap_unit.sv
// trap_unit: machine-mode interrupt/exception CSRs, trap entry FSM and mret handling.
module trap_unit
    import trap_unit_pkg::*;
#(
    parameter int USER_IRQ_COUNT  = 16,
    parameter bit VECTORED_ENABLE = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      csrWriteEnable,
    input  logic                      csrReadEnable,
    input  logic [11:0]               csrWriteAddress,
    input  logic [11:0]               csrReadAddress,
    input  logic [31:0]               csrWriteData,
    output logic [31:0]               csrReadData,
    output logic                      requestOutput,
    input  logic [31:0]               programCounter,
    input  logic                      instructionBoundary,
    input  logic                      exceptionValid,
    input  logic [4:0]                exceptionCause,
    input  logic [31:0]               exceptionValue,
    input  logic                      machineSoftwareIrq,
    input  logic                      machineTimerIrq,
    input  logic                      machineExternalIrq,
    input  logic [USER_IRQ_COUNT-1:0] userIrq,
    input  logic                      trapReturn,
    output logic                      trapTaken,
    output logic [31:0]               trapVector,
    output logic [31:0]               trapReturnVector,
    output logic                      interruptPending
);
    localparam logic [31:0] USER_MASK = (32'h0000_FFFF >> (16 - USER_IRQ_COUNT)) << 16;
    localparam logic [31:0] IMPL_MASK = USER_MASK | 32'h0000_0888;

    trapState_e state, stateNext;
    logic mstatusMie, mstatusMpie;
    logic [31:0] mieReg, mtvec, mscratch, mepc, mcause, mtval, trapVectorReg;
    logic [USER_IRQ_COUNT-1:0] edgeMode, edgePend, prevUser, edgeNext, edgeRise, edgeClear;
    logic [31:0] mipVal, mstatusVal, mirqVal, pendMasked, readValue, trapBase, vecNext, causeNext;
    logic irqValid, takeExc, takeIrq, doReturn, trapEntry;
    logic [4:0] irqCode;

    trap_irq_priority #(.USER_IRQ_COUNT(USER_IRQ_COUNT)) u_priority (
        .pending(pendMasked),
        .valid  (irqValid),
        .code   (irqCode)
    );

    always_comb begin
        mipVal = '0;
        mirqVal = '0;
        mstatusVal = '0;
        mipVal[MIP_MSI] = machineSoftwareIrq;
        mipVal[MIP_MTI] = machineTimerIrq;
        mipVal[MIP_MEI] = machineExternalIrq;
        for (int i = 0; i < USER_IRQ_COUNT; i++)
            mipVal[MIP_USER_BASE + i] = edgeMode[i] ? edgePend[i] : userIrq[i];
        mirqVal[MIP_USER_BASE +: USER_IRQ_COUNT] = edgeMode;
        mstatusVal[MSTATUS_MIE] = mstatusMie;
        mstatusVal[MSTATUS_MPIE] = mstatusMpie;
    end

    assign pendMasked = mipVal & mieReg;
    assign interruptPending = |pendMasked;

    // Edge pending: a new rising edge beats a same-cycle clear-by-write.
    assign edgeRise = userIrq & ~prevUser & edgeMode;
    assign edgeClear = (csrWriteEnable && csrWriteAddress == CSR_MIP)
                     ? ~csrWriteData[MIP_USER_BASE +: USER_IRQ_COUNT] : '0;
    assign edgeNext = ((edgePend & ~edgeClear) | edgeRise) & edgeMode;

    always_comb begin
        takeExc = 1'b0;
        takeIrq = 1'b0;
        doReturn = 1'b0;
        stateNext = RUN;
        if (state == RUN) begin
            takeExc = exceptionValid;
            takeIrq = !exceptionValid && !trapReturn && mstatusMie && irqValid && instructionBoundary;
            doReturn = trapReturn && !exceptionValid;
            stateNext = (takeExc || takeIrq) ? ENTRY : RUN;
        end
    end

    assign trapEntry = takeExc || takeIrq;
    assign trapBase = {mtvec[31:2], 2'b00};
    assign vecNext = (takeIrq && mtvec[0]) ? trapBase + {25'b0, irqCode, 2'b00} : trapBase;
    assign causeNext = takeExc ? {27'b0, exceptionCause} : {1'b1, 26'b0, irqCode};

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= stateNext;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatusMie <= 1'b0;
            mstatusMpie <= 1'b0;
            mieReg <= '0;
            mtvec <= '0;
            mscratch <= '0;
            mepc <= '0;
            mcause <= '0;
            mtval <= '0;
            edgeMode <= '0;
            edgePend <= '0;
            prevUser <= '0;
            trapVectorReg <= '0;
        end else begin
            prevUser <= userIrq;
            edgePend <= edgeNext;
            if (csrWriteEnable) begin
                if (csrWriteAddress == CSR_MIE) mieReg <= csrWriteData & IMPL_MASK;
                if (csrWriteAddress == CSR_MTVEC)
                    mtvec <= {csrWriteData[31:2], 1'b0, VECTORED_ENABLE && csrWriteData[1:0] == 2'b01};
                if (csrWriteAddress == CSR_MSCRATCH) mscratch <= csrWriteData;
                if (csrWriteAddress == CSR_MIRQMODE) edgeMode <= csrWriteData[MIP_USER_BASE +: USER_IRQ_COUNT];
                if (!trapEntry) begin
                    if (csrWriteAddress == CSR_MSTATUS) begin
                        mstatusMie <= csrWriteData[MSTATUS_MIE];
                        mstatusMpie <= csrWriteData[MSTATUS_MPIE];
                    end
                    if (csrWriteAddress == CSR_MEPC) mepc <= {csrWriteData[31:1], 1'b0};
                    if (csrWriteAddress == CSR_MCAUSE) mcause <= csrWriteData;
                    if (csrWriteAddress == CSR_MTVAL) mtval <= csrWriteData;
                end
            end
            if (doReturn) begin
                mstatusMie <= mstatusMpie;
                mstatusMpie <= 1'b1;
            end
            if (trapEntry) begin
                mepc <= {programCounter[31:1], 1'b0};
                mcause <= causeNext;
                mtval <= takeExc ? exceptionValue : '0;
                mstatusMpie <= mstatusMie;
                mstatusMie <= 1'b0;
                trapVectorReg <= vecNext;
            end
        end
    end

    always_comb begin
        readValue = '0;
        case (csrReadAddress)
            CSR_MSTATUS:  readValue = mstatusVal;
            CSR_MIE:      readValue = mieReg;
            CSR_MTVEC:    readValue = mtvec;
            CSR_MSCRATCH: readValue = mscratch;
            CSR_MEPC:     readValue = mepc;
            CSR_MCAUSE:   readValue = mcause;
            CSR_MTVAL:    readValue = mtval;
            CSR_MIP:      readValue = mipVal;
            CSR_MIRQMODE: readValue = mirqVal;
            default:      readValue = '0;
        endcase
    end

    assign requestOutput = csrReadEnable && isOwned(csrReadAddress);
    assign csrReadData = requestOutput ? readValue : '0;
    assign trapTaken = (state == ENTRY);
    assign trapVector = trapVectorReg;
    assign trapReturnVector = mepc;
endmodule

// File: tb/tb_trap_unit.sv
// tb_trap_unit: directed stimulus with a per-cycle reference model and literal spot checks for trap_unit.
`timescale 1ns/100ps
module tb_trap_unit;
    logic clk = 1'b0, rst = 1'b1;
    logic csrWriteEnable = 0, csrReadEnable = 0;
    logic [11:0] csrWriteAddress = 0, csrReadAddress = 0;
    logic [31:0] csrWriteData = 0, programCounter = 0, exceptionValue = 0;
    logic instructionBoundary = 0, exceptionValid = 0, trapReturn = 0;
    logic [4:0] exceptionCause = 0;
    logic machineSoftwareIrq = 0, machineTimerIrq = 0, machineExternalIrq = 0;
    logic [15:0] userIrq = 0;
    logic [31:0] csrReadData, trapVector, trapReturnVector;
    logic requestOutput, trapTaken, interruptPending;
    logic [31:0] csrReadDataNv, trapVectorNv, trapReturnVectorNv;
    logic requestOutputNv, trapTakenNv, interruptPendingNv;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    trap_unit #(.USER_IRQ_COUNT(16), .VECTORED_ENABLE(1)) dut (
        .clk(clk), .rst(rst), .csrWriteEnable(csrWriteEnable), .csrReadEnable(csrReadEnable),
        .csrWriteAddress(csrWriteAddress), .csrReadAddress(csrReadAddress), .csrWriteData(csrWriteData),
        .csrReadData(csrReadData), .requestOutput(requestOutput), .programCounter(programCounter),
        .instructionBoundary(instructionBoundary), .exceptionValid(exceptionValid),
        .exceptionCause(exceptionCause), .exceptionValue(exceptionValue),
        .machineSoftwareIrq(machineSoftwareIrq), .machineTimerIrq(machineTimerIrq),
        .machineExternalIrq(machineExternalIrq), .userIrq(userIrq), .trapReturn(trapReturn),
        .trapTaken(trapTaken), .trapVector(trapVector), .trapReturnVector(trapReturnVector),
        .interruptPending(interruptPending));

    trap_unit #(.USER_IRQ_COUNT(16), .VECTORED_ENABLE(0)) dutNv (
        .clk(clk), .rst(rst), .csrWriteEnable(csrWriteEnable), .csrReadEnable(csrReadEnable),
        .csrWriteAddress(csrWriteAddress), .csrReadAddress(csrReadAddress), .csrWriteData(csrWriteData),
        .csrReadData(csrReadDataNv), .requestOutput(requestOutputNv), .programCounter(programCounter),
        .instructionBoundary(instructionBoundary), .exceptionValid(exceptionValid),
        .exceptionCause(exceptionCause), .exceptionValue(exceptionValue),
        .machineSoftwareIrq(machineSoftwareIrq), .machineTimerIrq(machineTimerIrq),
        .machineExternalIrq(machineExternalIrq), .userIrq(userIrq), .trapReturn(trapReturn),
        .trapTaken(trapTakenNv), .trapVector(trapVectorNv), .trapReturnVector(trapReturnVectorNv),
        .interruptPending(interruptPendingNv));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    // Reference model state (VECTORED_ENABLE=1 instance).
    logic mMie = 0, mMpie = 0, mEntry = 0;
    logic [31:0] mIe = 0, mTvec = 0, mScratch = 0, mEpc = 0, mCause = 0, mTval = 0, mVec = 0;
    logic [15:0] mMode = 0, mPend = 0, mPrev = 0;

    function automatic logic [31:0] modelMip();
        logic [31:0] r = 0;
        r[3] = machineSoftwareIrq;
        r[7] = machineTimerIrq;
        r[11] = machineExternalIrq;
        for (int i = 0; i < 16; i++) r[16 + i] = mMode[i] ? mPend[i] : userIrq[i];
        return r;
    endfunction

    function automatic int modelCode(input logic [31:0] p);
        if (p[11]) return 11;
        if (p[3]) return 3;
        if (p[7]) return 7;
        for (int c = 16; c < 32; c++) if (p[c]) return c;
        return -1;
    endfunction

    function automatic logic [32:0] modelRead(input logic [11:0] a);
        case (a)
            12'h300: return {1'b1, 24'b0, mMpie, 3'b0, mMie, 3'b0};
            12'h304: return {1'b1, mIe};
            12'h305: return {1'b1, mTvec};
            12'h340: return {1'b1, mScratch};
            12'h341: return {1'b1, mEpc};
            12'h342: return {1'b1, mCause};
            12'h343: return {1'b1, mTval};
            12'h344: return {1'b1, modelMip()};
            12'h7C0: return {1'b1, mMode, 16'b0};
            default: return 33'b0;
        endcase
    endfunction

    task automatic modelStep();
        logic oMie, oMpie, exc, irq, wr;
        logic [15:0] newPend;
        logic [31:0] base;
        int code;
        if (rst) begin
            {mMie, mMpie, mEntry} = 0;
            {mIe, mTvec, mScratch, mEpc, mCause, mTval, mVec} = 0;
            {mMode, mPend, mPrev} = 0;
            return;
        end
        oMie = mMie;
        oMpie = mMpie;
        code = modelCode(modelMip() & mIe);
        exc = !mEntry && exceptionValid;
        irq = !mEntry && !exceptionValid && !trapReturn && oMie && code >= 0 && instructionBoundary;
        wr = csrWriteEnable;
        for (int i = 0; i < 16; i++)
            newPend[i] = mMode[i] && ((mPend[i] && !(wr && csrWriteAddress == 12'h344 && !csrWriteData[16 + i]))
                                      || (userIrq[i] && !mPrev[i]));
        if (wr) begin
            case (csrWriteAddress)
                12'h304: mIe = csrWriteData & 32'hFFFF_0888;
                12'h305: mTvec = (csrWriteData & ~32'd3) | ((csrWriteData[1:0] == 2'b01) ? 32'd1 : 32'd0);
                12'h340: mScratch = csrWriteData;
                12'h7C0: mMode = csrWriteData[31:16];
                12'h300: if (!(exc || irq)) begin mMie = csrWriteData[3]; mMpie = csrWriteData[7]; end
                12'h341: if (!(exc || irq)) mEpc = csrWriteData & ~32'd1;
                12'h342: if (!(exc || irq)) mCause = csrWriteData;
                12'h343: if (!(exc || irq)) mTval = csrWriteData;
                default: ;
            endcase
        end
        if (!mEntry && trapReturn && !exceptionValid) begin
            mMie = oMpie;
            mMpie = 1'b1;
        end
        if (exc || irq) begin
            mEpc = programCounter & ~32'd1;
            mCause = exc ? {27'b0, exceptionCause} : (32'h8000_0000 | 32'(code));
            mTval = exc ? exceptionValue : 32'd0;
            mMpie = oMie;
            mMie = 1'b0;
            base = mTvec & ~32'd3;
            mVec = (irq && mTvec[0]) ? base + 32'(4 * code) : base;
        end
        mPend = newPend;
        mPrev = userIrq;
        mEntry = exc || irq;
    endtask

    always @(posedge clk) begin
        logic [32:0] r;
        modelStep();
        #1;
        r = modelRead(csrReadAddress);
        check("trapTaken", {31'b0, trapTaken}, {31'b0, mEntry});
        if (mEntry) check("trapVector", trapVector, mVec);
        check("trapReturnVector", trapReturnVector, mEpc);
        check("interruptPending", {31'b0, interruptPending}, {31'b0, |(modelMip() & mIe)});
        check("requestOutput", {31'b0, requestOutput}, {31'b0, csrReadEnable && r[32]});
        check("csrReadData", csrReadData, csrReadEnable ? r[31:0] : 32'd0);
    end

    task automatic wrCsr(input logic [11:0] a, input logic [31:0] d);
        csrWriteEnable = 1; csrWriteAddress = a; csrWriteData = d;
        @(negedge clk);
        csrWriteEnable = 0;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] want, input string name);
        csrReadEnable = 1; csrReadAddress = a;
        #0.2;
        check(name, csrReadData, want);
        csrReadEnable = 0;
    endtask

    task automatic cyc(); @(negedge clk); endtask

    initial begin
        repeat (3) cyc();
        rst = 0;
        check("rst trapTaken", {31'b0, trapTaken}, 32'd0);
        check("rst trapVector", trapVector, 32'd0);
        rd(12'h300, 32'd0, "rst mstatus");
        rd(12'h305, 32'd0, "rst mtvec");
        rd(12'h123, 32'd0, "unowned read");
        // Synchronous exception
        wrCsr(12'h305, 32'h200);
        programCounter = 32'h100; exceptionValid = 1; exceptionCause = 5'd2; exceptionValue = 32'hDEAD0013;
        cyc();
        exceptionValid = 0;
        check("exc trapTaken", {31'b0, trapTaken}, 32'd1);
        check("exc trapVector", trapVector, 32'h200);
        rd(12'h341, 32'h100, "exc mepc");
        rd(12'h342, 32'd2, "exc mcause");
        rd(12'h343, 32'hDEAD0013, "exc mtval");
        rd(12'h300, 32'd0, "exc mstatus");
        cyc();
        check("exc pulse end", {31'b0, trapTaken}, 32'd0);
        // Vectored timer interrupt and WARL mtvec on the non-vectored instance
        wrCsr(12'h305, 32'h401);
        csrReadEnable = 1; csrReadAddress = 12'h305; #0.2;
        check("novec mtvec", csrReadDataNv, 32'h400);
        check("vec mtvec", csrReadData, 32'h401);
        csrReadEnable = 0;
        wrCsr(12'h304, 32'h80);
        wrCsr(12'h300, 32'h8);
        programCounter = 32'h2345; machineTimerIrq = 1;
        #0.2;
        check("mti pending", {31'b0, interruptPending}, 32'd1);
        instructionBoundary = 1;
        cyc();
        instructionBoundary = 0; machineTimerIrq = 0;
        check("mti trapTaken", {31'b0, trapTaken}, 32'd1);
        check("mti trapVector", trapVector, 32'h41C);
        rd(12'h342, 32'h8000_0007, "mti mcause");
        rd(12'h341, 32'h2344, "mti mepc");
        rd(12'h343, 32'd0, "mti mtval");
        rd(12'h300, 32'h80, "mti mstatus");
        cyc();
        // mret
        trapReturn = 1; cyc(); trapReturn = 0;
        rd(12'h300, 32'h88, "mret mstatus");
        check("mret vector", trapReturnVector, 32'h2344);
        // Priority
        wrCsr(12'h304, 32'hFFFF_0888);
        machineExternalIrq = 1; machineSoftwareIrq = 1; userIrq = 16'h0001; instructionBoundary = 1;
        cyc();
        instructionBoundary = 0; machineExternalIrq = 0; machineSoftwareIrq = 0; userIrq = 0;
        rd(12'h342, 32'h8000_000B, "prio mei mcause");
        check("prio mei vector", trapVector, 32'h42C);
        cyc();
        trapReturn = 1; cyc(); trapReturn = 0;
        userIrq = 16'h0024; instructionBoundary = 1;
        cyc();
        instructionBoundary = 0; userIrq = 0;
        rd(12'h342, 32'h8000_0012, "prio user mcause");
        check("prio user vector", trapVector, 32'h448);
        cyc();
        trapReturn = 1; cyc(); trapReturn = 0;
        // Edge-mode user interrupt
        wrCsr(12'h304, 32'd0);
        wrCsr(12'h7C0, 32'h0002_0000);
        userIrq = 16'h0002; cyc(); userIrq = 0; cyc();
        rd(12'h344, 32'h0002_0000, "edge sticky");
        csrWriteEnable = 1; csrWriteAddress = 12'h344; csrWriteData = 0; userIrq = 16'h0002;
        cyc();
        csrWriteEnable = 0;
        rd(12'h344, 32'h0002_0000, "edge set wins");
        userIrq = 0;
        wrCsr(12'h344, 32'd0);
        rd(12'h344, 32'd0, "edge cleared");
        userIrq = 16'h0008;
        rd(12'h344, 32'h0008_0000, "level mirror");
        userIrq = 0;
        // Exception with MIE=0, colliding mepc write and mret, held across ENTRY
        wrCsr(12'h300, 32'd0);
        programCounter = 32'h301; exceptionValid = 1; exceptionCause = 5'd5; exceptionValue = 32'd7;
        csrWriteEnable = 1; csrWriteAddress = 12'h341; csrWriteData = 32'h999; trapReturn = 1;
        cyc();
        csrWriteEnable = 0; trapReturn = 0;
        check("coll trapTaken", {31'b0, trapTaken}, 32'd1);
        rd(12'h341, 32'h300, "coll mepc");
        rd(12'h300, 32'd0, "coll mstatus");
        cyc();
        exceptionValid = 0;
        check("entry ignores exc", {31'b0, trapTaken}, 32'd0);
        rd(12'h342, 32'd5, "coll mcause");
        // Reset during ENTRY
        exceptionValid = 1; cyc(); exceptionValid = 0;
        check("pre-rst trapTaken", {31'b0, trapTaken}, 32'd1);
        rst = 1; cyc(); rst = 0;
        check("rst abort trapTaken", {31'b0, trapTaken}, 32'd0);
        check("rst abort trapVector", trapVector, 32'd0);
        rd(12'h305, 32'd0, "rst abort mtvec");
        cyc();
        check("no late pulse", {31'b0, trapTaken}, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/trap_unit.md
TRAP_UNIT -- requirements
Module: trap_unit

Interface
REQ-001 SHALL have parameter USER_IRQ_COUNT, default 16, range 1..16: number of user interrupt lines.
REQ-002 SHALL have parameter VECTORED_ENABLE, default 1: 1 permits mtvec vectored mode.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 csrWriteEnable, csrReadEnable  in  1 each  CSR access strobes.
REQ-006 csrWriteAddress, csrReadAddress  in  12 each  CSR addresses.
REQ-007 csrWriteData  in  32 / csrReadData  out  32  CSR data; csrReadData=0 when no owned address.
REQ-008 requestOutput  out  1  high when csrReadEnable and csrReadAddress is owned here.
REQ-009 programCounter  in  32  PC of the instruction at the boundary.
REQ-010 instructionBoundary  in  1  core can accept an interrupt this cycle.
REQ-011 exceptionValid  in  1 / exceptionCause  in  5 / exceptionValue  in  32  synchronous exception report.
REQ-012 machineSoftwareIrq, machineTimerIrq, machineExternalIrq  in  1 each; userIrq  in  USER_IRQ_COUNT.
REQ-013 trapReturn  in  1  mret pulse.
REQ-014 trapTaken  out  1  one-cycle entry pulse / trapVector  out  32  handler address, valid while trapTaken.
REQ-015 trapReturnVector  out  32  current mepc / interruptPending  out  1  any enabled pending interrupt.

Function
REQ-016 Owned CSRs SHALL be: mstatus 0x300 (MIE bit3, MPIE bit7), mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344, mirqmode 0x7C0.
REQ-017 mip SHALL map MSI bit3, MTI bit7, MEI bit11, userIrq[i] bit16+i; unimplemented bits read 0 and ignore writes.
REQ-018 mirqmode bit16+i SHALL select edge (1) or level (0) for userIrq[i]; machine lines always level.
REQ-019 Level bits in mip SHALL mirror the input and ignore writes; edge bits SHALL set on a 0->1 input transition (previous sample registered) and clear on CSR write of 0; set wins over simultaneous clear.
REQ-020 mtvec mode SHALL be WARL: written mode 01 kept only if VECTORED_ENABLE, otherwise mode=00; base bits[1:0] always 0.
REQ-021 mepc bit0 SHALL always read 0.
REQ-022 Interrupt eligible when MIE=1 and (mip & mie)!=0; interruptPending = |(mip & mie) regardless of MIE.
REQ-023 Priority SHALL be MEI > MSI > MTI > userIrq lowest index first; mcause code 11, 3, 7, 16+i respectively.
REQ-024 FSM states RUN and ENTRY; RUN->ENTRY when exceptionValid, or interrupt eligible and instructionBoundary; ENTRY->RUN unconditionally.
REQ-025 Exception SHALL win over interrupt in the same cycle and SHALL be taken regardless of MIE.
REQ-026 On RUN->ENTRY edge: mepc<=programCounter&~1, mcause<={isInterrupt,26'b0,code}, mtval<=exceptionValue (exception) or 0 (interrupt), MPIE<=MIE, MIE<=0.
REQ-027 trapTaken SHALL be 1 exactly in ENTRY; latency one cycle from detection.
REQ-028 trapVector SHALL be registered: base+4*code for interrupts in vectored mode, else base.
REQ-029 Trap detection SHALL be ignored while in ENTRY.
REQ-030 trapReturn in RUN SHALL set MIE<=MPIE, MPIE<=1; interrupts not sampled that cycle; an exception in the same cycle wins and trapReturn is dropped.
REQ-031 A CSR write colliding with trap entry on mstatus/mepc/mcause/mtval SHALL be discarded.
REQ-032 CSR reads SHALL be combinational, same cycle as csrReadEnable.

Reset
REQ-033 rst SHALL clear all CSRs, edge-detect history and edge pending bits, set state RUN, trapTaken=0, trapVector=0.
REQ-034 rst during ENTRY SHALL abort the entry; no pulse follows.

Structure
REQ-035 CSR addresses, mcause codes, mip bit positions and FSM state encodings SHALL live in shared package trap_unit_pkg.
REQ-036 Priority selection SHALL be sub-module trap_irq_priority (masked pending vector in; valid and code out).

Verification
REQ-037 Exception: exceptionValid=1, cause=2, value=0xDEAD0013, PC=0x100, mtvec=0x200 -> trapTaken next cycle, trapVector=0x200, mepc=0x100, mcause=2, mtval=0xDEAD0013, MIE=0.
REQ-038 Vectored: mtvec=0x401, MIE=1, mie bit7=1, MTI=1, boundary=1 -> mcause=0x80000007, trapVector=0x41C.
REQ-039 Priority: MEI, MSI, userIrq[0] together, all enabled -> mcause code 11; userIrq[2]+userIrq[5] only -> code 18.
REQ-040 Edge: mirqmode bit17=1, pulse userIrq[1] one cycle -> mip bit17 stays 1; CSR write 0 with simultaneous new edge -> bit17 remains 1.
REQ-041 Return: MPIE=1, trapReturn -> MIE=1, MPIE=1, trapReturnVector=mepc; VECTORED_ENABLE=0 write mtvec=0x401 -> reads 0x400.
